// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit LCD timing engine: turns CPU command words into nibble/RS/E sequences
// and samples the shared push buttons while the bus is idle. Optional: LCD_PB_DEBOUNCE_EN.
module lcd_nibble_driver #(
   parameter int SETUP_CYCLES     = 3,
   parameter int E_HIGH_CYCLES    = 25,
   parameter int HOLD_CYCLES      = 25,
   parameter int CMD_WAIT_CYCLES  = 2500,
   parameter int LONG_WAIT_CYCLES = 100000,
   parameter int DEBOUNCE_CYCLES  = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] lcd_in,
   input  logic        lcd_in_stb,
   output logic        lcd_in_ack,
   output logic [3:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_oe,
   output logic        lcd_e,
   input  logic [3:0]  lcd_data_i,
   input  logic        lcd_rs_i,
   output logic [31:0] pb_out,
   output logic        busy
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // A zero-length phase still takes one clock.
   function automatic int last_cnt(input int n);
      return (n <= 1) ? 0 : n - 1;
   endfunction

   localparam int MAX_CYC = max2(max2(max2(SETUP_CYCLES, E_HIGH_CYCLES),
                                      max2(HOLD_CYCLES, CMD_WAIT_CYCLES)),
                                 max2(LONG_WAIT_CYCLES, DEBOUNCE_CYCLES));
   localparam int CNT_W = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(last_cnt(SETUP_CYCLES));
   localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(last_cnt(E_HIGH_CYCLES));
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(last_cnt(HOLD_CYCLES));
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(last_cnt(CMD_WAIT_CYCLES));
   localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(last_cnt(LONG_WAIT_CYCLES));

   typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       low_nib;
   logic             single_nib;
   logic             long_wait;
   logic             second;
   logic [4:0]       sync_a;
   logic [4:0]       sync_b;
   logic [1:0]       idle_cnt;
   logic             pb_ok;
   logic             unused_hi;

   assign unused_hi = ^lcd_in[31:11];
   assign busy      = (state != IDLE);
   assign pb_ok     = (state == IDLE) && (idle_cnt == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         low_nib    <= '0;
         single_nib <= 1'b0;
         long_wait  <= 1'b0;
         second     <= 1'b0;
         lcd_in_ack <= 1'b0;
         lcd_data_o <= '0;
         lcd_rs_o   <= 1'b0;
         lcd_oe     <= 1'b0;
         lcd_e      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (lcd_in_stb && lcd_in_ack) begin
                  lcd_in_ack <= 1'b0;
                  low_nib    <= lcd_in[3:0];
                  single_nib <= lcd_in[9];
                  long_wait  <= lcd_in[10];
                  second     <= 1'b0;
                  lcd_rs_o   <= lcd_in[8];
                  lcd_data_o <= lcd_in[7:4];
                  lcd_oe     <= 1'b1;
                  cnt        <= '0;
                  state      <= SETUP;
               end else begin
                  lcd_in_ack <= lcd_in_stb && !lcd_in_ack;
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt   <= '0;
                  lcd_e <= 1'b1;
                  state <= EHIGH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EHIGH: begin
               if (cnt == EHIGH_LAST) begin
                  cnt   <= '0;
                  lcd_e <= 1'b0;
                  state <= HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt <= '0;
                  if (!second && !single_nib) begin
                     second     <= 1'b1;
                     lcd_data_o <= low_nib;
                     state      <= SETUP;
                  end else begin
                     lcd_oe <= 1'b0;
                     state  <= WAIT;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT: begin
               if (cnt == (long_wait ? LONG_LAST : CMD_LAST)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt    <= '0;
               lcd_e  <= 1'b0;
               lcd_oe <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Buttons share the pads, so only trust them a couple of clocks after the bus is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a   <= '0;
         sync_b   <= '0;
         idle_cnt <= '0;
      end else begin
         sync_a <= {lcd_rs_i, lcd_data_i};
         sync_b <= sync_a;
         if (state != IDLE) begin
            idle_cnt <= '0;
         end else if (idle_cnt != 2'd2) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

`ifdef LCD_PB_DEBOUNCE_EN
   localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(last_cnt(DEBOUNCE_CYCLES));

   logic [DB_W-1:0] db_cnt;
   logic [4:0]      db_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pb_out  <= '0;
         db_cnt  <= '0;
         db_last <= '0;
      end else if (!pb_ok) begin
         db_cnt <= '0;
      end else if (sync_b != db_last) begin
         db_last <= sync_b;
         db_cnt  <= '0;
      end else if (db_cnt == DB_LAST) begin
         pb_out <= {27'd0, db_last};
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pb_out <= '0;
      end else if (pb_ok) begin
         pb_out <= {27'd0, sync_b};
      end
   end
`endif

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Self-checking bench for lcd_nibble_driver: directed words plus random words scored
// against a nibble-list / busy-length model derived from the command word fields.
module tb_lcd_nibble_driver;

   localparam int S  = 3;
   localparam int EH = 25;
   localparam int H  = 25;
   localparam int CW = 2500;
   localparam int LW = 300;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lcd_in;
   logic        lcd_in_stb;
   logic        lcd_in_ack;
   logic [3:0]  lcd_data_o;
   logic        lcd_rs_o;
   logic        lcd_oe;
   logic        lcd_e;
   logic [3:0]  lcd_data_i;
   logic        lcd_rs_i;
   logic [31:0] pb_out;
   logic        busy;

   int total = 0;
   int bad   = 0;

   int          n_pulses;
   logic [3:0]  p_nib [4];
   logic        p_rs  [4];
   int          p_w   [4];
   int          busy_n, oe_n, e_no_oe, unstable, acks_busy, pb_moves;
   logic [31:0] next_w;
   bit          hold_stb;
   int          flip_at;

   always #10 clk = ~clk;

   lcd_nibble_driver #(
      .SETUP_CYCLES    (S),
      .E_HIGH_CYCLES   (EH),
      .HOLD_CYCLES     (H),
      .CMD_WAIT_CYCLES (CW),
      .LONG_WAIT_CYCLES(LW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lcd_in     (lcd_in),
      .lcd_in_stb (lcd_in_stb),
      .lcd_in_ack (lcd_in_ack),
      .lcd_data_o (lcd_data_o),
      .lcd_rs_o   (lcd_rs_o),
      .lcd_oe     (lcd_oe),
      .lcd_e      (lcd_e),
      .lcd_data_i (lcd_data_i),
      .lcd_rs_i   (lcd_rs_i),
      .pb_out     (pb_out),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called on a negedge; returns on the first negedge with busy low again.
   task automatic run_xfer(input logic [31:0] w);
      int          i;
      logic        pe;
      logic [31:0] pb0;
      logic [3:0]  nib [$];
      int          exp_busy;
      lcd_in     = w;
      lcd_in_stb = 1'b1;
      i = 0;
      while (!lcd_in_ack && i < 10) begin
         @(negedge clk);
         i++;
      end
      chk("ack_seen", {31'd0, lcd_in_ack}, 32'd1);
      chk("ack_latency", i, 1);
      @(negedge clk);
      chk("ack_one_cycle", {31'd0, lcd_in_ack}, 32'd0);
      if (hold_stb) lcd_in = next_w;
      else lcd_in_stb = 1'b0;
      n_pulses = 0; busy_n = 0; oe_n = 0; e_no_oe = 0;
      unstable = 0; acks_busy = 0; pb_moves = 0;
      pb0 = pb_out;
      pe  = 1'b0;
      while (busy && busy_n < 10000) begin
         busy_n++;
         if (flip_at == busy_n) lcd_data_i = 4'hF;
         if (lcd_oe) oe_n++;
         if (lcd_in_ack) acks_busy++;
         if (pb_out !== pb0) pb_moves++;
         if (lcd_e && !lcd_oe) e_no_oe++;
         if (lcd_e && !pe) begin
            if (n_pulses < 4) begin
               p_nib[n_pulses] = lcd_data_o;
               p_rs[n_pulses]  = lcd_rs_o;
               p_w[n_pulses]   = 0;
            end
            n_pulses++;
         end
         if (lcd_e && n_pulses > 0 && n_pulses <= 4) begin
            p_w[n_pulses-1]++;
            if (lcd_data_o !== p_nib[n_pulses-1] || lcd_rs_o !== p_rs[n_pulses-1]) unstable++;
         end
         pe = lcd_e;
         @(negedge clk);
      end
      // Reference: high nibble always, low nibble unless single, then the selected wait.
      nib.push_back(w[7:4]);
      if (!w[9]) nib.push_back(w[3:0]);
      exp_busy = nib.size() * (S + EH + H) + (w[10] ? LW : CW);
      chk("pulse_count", n_pulses, nib.size());
      for (int j = 0; j < nib.size() && j < n_pulses; j++) begin
         chk("pulse_nibble", {28'd0, p_nib[j]}, {28'd0, nib[j]});
         chk("pulse_rs", {31'd0, p_rs[j]}, {31'd0, w[8]});
         chk("pulse_width", p_w[j], EH);
      end
      chk("busy_cycles", busy_n, exp_busy);
      chk("oe_cycles", oe_n, nib.size() * (S + EH + H));
      chk("e_without_oe", e_no_oe, 0);
      chk("bus_unstable_in_e", unstable, 0);
      chk("ack_while_busy", acks_busy, 0);
      chk("pb_moved_while_busy", pb_moves, 0);
      chk("end_oe", {31'd0, lcd_oe}, 32'd0);
      chk("end_e", {31'd0, lcd_e}, 32'd0);
   endtask

   initial begin
      int i;
      logic [31:0] w;
      rst_n = 1'b0; lcd_in = '0; lcd_in_stb = 1'b0;
      lcd_data_i = 4'hA; lcd_rs_i = 1'b1;
      hold_stb = 1'b0; flip_at = 0; next_w = '0;
      repeat (2) @(negedge clk);
      chk("rst_e", {31'd0, lcd_e}, 32'd0);
      chk("rst_oe", {31'd0, lcd_oe}, 32'd0);
      chk("rst_data", {28'd0, lcd_data_o}, 32'd0);
      chk("rst_rs", {31'd0, lcd_rs_o}, 32'd0);
      chk("rst_ack", {31'd0, lcd_in_ack}, 32'd0);
      chk("rst_pb", pb_out, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_pb", pb_out, 32'h1A);
      chk("idle_oe", {31'd0, lcd_oe}, 32'd0);
      chk("idle_e", {31'd0, lcd_e}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      run_xfer(32'h0000_0148);
      run_xfer(32'h0000_0230);

      // Long wait with the next word already presented: no ack until IDLE.
      next_w   = 32'h0000_0128;
      hold_stb = 1'b1;
      run_xfer(32'h0000_0401);
      hold_stb = 1'b0;
      run_xfer(next_w);

      // Buttons change mid-transfer; pb_out must wait for the idle turnaround.
      lcd_data_i = 4'h0; lcd_rs_i = 1'b1;
      repeat (4) @(negedge clk);
      chk("pb_before", pb_out, 32'h10);
      flip_at = 10;
      run_xfer(32'h0000_0155);
      flip_at = 0;
      chk("pb_turnaround0", pb_out, 32'h10);
      @(negedge clk);
      chk("pb_turnaround1", pb_out, 32'h10);
      repeat (4) @(negedge clk);
      chk("pb_after", pb_out, 32'h1F);

      for (int k = 0; k < 6; k++) begin
         w = $urandom;
         run_xfer(w);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Reset while E is high.
      lcd_in = 32'h0000_01A7; lcd_in_stb = 1'b1;
      i = 0;
      while (!lcd_in_ack && i < 10) begin
         @(negedge clk);
         i++;
      end
      @(negedge clk);
      lcd_in_stb = 1'b0;
      i = 0;
      while (!lcd_e && i < 20) begin
         @(negedge clk);
         i++;
      end
      chk("reached_ehigh", {31'd0, lcd_e}, 32'd1);
      repeat (5) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_e", {31'd0, lcd_e}, 32'd0);
      chk("midrst_oe", {31'd0, lcd_oe}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_data", {28'd0, lcd_data_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("postrst_busy", {31'd0, busy}, 32'd0);
      run_xfer(32'h0000_01A7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
